// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arbiter_pkg;
   localparam int WORD_W           = 16;
   localparam int STARVE_W         = 3;
   localparam int STARVE_LIMIT_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      D_ACC = 2'd1,
      I_ACC = 2'd2,
      RESP  = 2'd3
   } arb_state_e;
endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one shared single-port memory between instruction fetch and data
// accesses; one access outstanding, data preferred until fetch starvation limit.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [WORD_W-1:0] if_addr,
   output logic [WORD_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [WORD_W-1:0] d_addr,
   input  logic [WORD_W-1:0] d_wdata,
   output logic [WORD_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              stall
);

   localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

   arb_state_e          state, state_nxt;
   logic [STARVE_W-1:0] starve_cnt;
   logic                d_pend;
   logic                grant_d, grant_i;
   logic                done_d, done_i;

   assign d_pend  = d_rd | d_wr;
   assign mem_req = (state == D_ACC) || (state == I_ACC);
   assign done_d  = (state == D_ACC) && mem_ready;
   assign done_i  = (state == I_ACC) && mem_ready;
   assign stall   = (if_req & ~if_ready) | (d_pend & ~d_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_d   = 1'b0;
      grant_i   = 1'b0;
      case (state)
         IDLE: begin
            // Data wins contention unless the fetch has already been passed over LIMIT times.
            if (d_pend && !(if_req && (starve_cnt == LIMIT))) begin
               grant_d   = 1'b1;
               state_nxt = D_ACC;
            end else if (if_req) begin
               grant_i   = 1'b1;
               state_nxt = I_ACC;
            end
         end
         D_ACC:   if (mem_ready) state_nxt = RESP;
         I_ACC:   if (mem_ready) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         if_ready   <= 1'b0;
         d_ready    <= 1'b0;
      end else begin
         if_ready <= done_i;
         d_ready  <= done_d;
         if (grant_d) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_we    <= d_wr;
            if (if_req && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + 1'b1;
         end
         if (grant_i) begin
            mem_addr   <= if_addr;
            mem_we     <= 1'b0;
            starve_cnt <= '0;
         end
         if (done_i)            if_rdata <= mem_rdata;
         // Writes leave the last read value visible to the data port.
         if (done_d && !mem_we) d_rdata  <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_rd, d_wr;
   logic [15:0] if_addr, d_addr, d_wdata;
   logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_ready, d_ready, mem_req, mem_we, mem_ready, stall;

   logic [3:0]  wait_cfg;
   logic [3:0]  wcnt;
   int          n_vec = 0;
   int          n_err = 0;

   mem_arbiter #(.STARVE_LIMIT(3)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom(input logic [15:0] a);
      case (a)
         16'h0040: rom = 16'hBEEF;
         16'h0020: rom = 16'h2020;
         16'h0050: rom = 16'h5050;
         16'h0100: rom = 16'hC0DE;
         16'h0070: rom = 16'h5A5A;
         default:  rom = a ^ 16'hFFFF;
      endcase
   endfunction

   // Memory answers after wait_cfg stalled cycles of mem_req.
   always @(posedge clk or posedge reset) begin
      if (reset)                     wcnt <= '0;
      else if (mem_req && !mem_ready) wcnt <= wcnt + 4'd1;
      else                           wcnt <= '0;
   end
   assign mem_ready = mem_req && (wcnt == wait_cfg);
   assign mem_rdata = rom(mem_addr);

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   logic [15:0] starve_addr [15];

   initial begin
      reset = 1'b1; if_req = 0; d_rd = 0; d_wr = 0;
      if_addr = '0; d_addr = '0; d_wdata = '0; wait_cfg = 4'd0;
      for (int i = 0; i < 15; i++) starve_addr[i] = 16'h0050;
      starve_addr[10] = 16'h0030;

      // Reset values
      repeat (2) @(posedge clk);
      mid;
      check_eq("rst_mem_req",  mem_req,  0);
      check_eq("rst_mem_we",   mem_we,   0);
      check_eq("rst_mem_addr", mem_addr, 0);
      check_eq("rst_if_rdy",   if_ready, 0);
      check_eq("rst_d_rdy",    d_ready,  0);
      next_cyc; reset = 1'b0;

      // Zero-wait read
      next_cyc; d_rd = 1; d_addr = 16'h0040;
      mid; check_eq("rd_c0_req", mem_req, 0); check_eq("rd_c0_stall", stall, 1);
      next_cyc;
      mid; check_eq("rd_c1_req", mem_req, 1); check_eq("rd_c1_we", mem_we, 0);
      check_eq("rd_c1_addr", mem_addr, 16'h0040);
      next_cyc;
      mid; check_eq("rd_c2_rdy", d_ready, 1); check_eq("rd_c2_data", d_rdata, 16'hBEEF);
      check_eq("rd_c2_stall", stall, 0); check_eq("rd_c2_req", mem_req, 0);
      next_cyc; d_rd = 0;
      mid; check_eq("rd_c3_stall", stall, 0); check_eq("rd_c3_rdy", d_ready, 0);

      // Contention: write first, then fetch
      next_cyc; if_req = 1; if_addr = 16'h0020; d_wr = 1; d_addr = 16'h0010; d_wdata = 16'h1234;
      mid; check_eq("ct_c0_req", mem_req, 0); check_eq("ct_c0_stall", stall, 1);
      next_cyc;
      mid; check_eq("ct_c1_req", mem_req, 1); check_eq("ct_c1_we", mem_we, 1);
      check_eq("ct_c1_addr", mem_addr, 16'h0010); check_eq("ct_c1_wdata", mem_wdata, 16'h1234);
      next_cyc;
      mid; check_eq("ct_c2_drdy", d_ready, 1); check_eq("ct_c2_irdy", if_ready, 0);
      next_cyc; d_wr = 0;
      mid; check_eq("ct_c3_req", mem_req, 0); check_eq("ct_c3_stall", stall, 1);
      next_cyc;
      mid; check_eq("ct_c4_req", mem_req, 1); check_eq("ct_c4_we", mem_we, 0);
      check_eq("ct_c4_addr", mem_addr, 16'h0020);
      next_cyc;
      mid; check_eq("ct_c5_irdy", if_ready, 1); check_eq("ct_c5_idata", if_rdata, 16'h2020);
      check_eq("ct_c5_drdy", d_ready, 0);
      next_cyc; if_req = 0;
      mid;

      // Starvation: three data grants, one fetch, then data wins again
      for (int c = 0; c < 15; c++) begin
         next_cyc;
         if (c == 0) begin
            if_req = 1; if_addr = 16'h0030; d_rd = 1; d_addr = 16'h0050;
         end
         if (c == 14) begin
            if_req = 0; d_rd = 0;
         end
         mid;
         check_eq($sformatf("sv_c%0d_req", c), mem_req, ((c % 3) == 1) ? 16'd1 : 16'd0);
         if ((c % 3) == 1)
            check_eq($sformatf("sv_c%0d_addr", c), mem_addr, starve_addr[c]);
         if (c == 11) check_eq("sv_c11_idata", if_rdata, 16'hFFCF);
         check_eq($sformatf("sv_c%0d_irdy", c), if_ready, (c == 11) ? 16'd1 : 16'd0);
         if (c == 14) check_eq("sv_c14_drdy", d_ready, 1);
      end
      next_cyc;
      mid; check_eq("sv_end_req", mem_req, 0);

      // Fetch with four wait states
      wait_cfg = 4'd4;
      next_cyc; if_req = 1; if_addr = 16'h0100;
      mid;
      for (int c = 1; c <= 5; c++) begin
         next_cyc;
         mid;
         check_eq($sformatf("ws_c%0d_req", c), mem_req, 1);
         check_eq($sformatf("ws_c%0d_addr", c), mem_addr, 16'h0100);
         check_eq($sformatf("ws_c%0d_stall", c), stall, 1);
         check_eq($sformatf("ws_c%0d_mrdy", c), mem_ready, (c == 5) ? 16'd1 : 16'd0);
         check_eq($sformatf("ws_c%0d_irdy", c), if_ready, 0);
      end
      next_cyc;
      mid; check_eq("ws_c6_irdy", if_ready, 1); check_eq("ws_c6_idata", if_rdata, 16'hC0DE);
      check_eq("ws_c6_stall", stall, 0);
      next_cyc; if_req = 0;
      mid;

      // Reset during a data write access
      wait_cfg = 4'd3;
      next_cyc; d_wr = 1; d_addr = 16'h0060; d_wdata = 16'h7777;
      mid;
      next_cyc;
      mid; check_eq("ra_c1_req", mem_req, 1); check_eq("ra_c1_we", mem_we, 1);
      next_cyc;
      #2 reset = 1; d_wr = 0; d_rd = 1; d_addr = 16'h0070; wait_cfg = 4'd0;
      #1;
      check_eq("ra_req",    mem_req,   0);
      check_eq("ra_we",     mem_we,    0);
      check_eq("ra_addr",   mem_addr,  0);
      check_eq("ra_wdata",  mem_wdata, 0);
      check_eq("ra_drdata", d_rdata,   0);
      check_eq("ra_irdata", if_rdata,  0);
      check_eq("ra_drdy",   d_ready,   0);
      check_eq("ra_irdy",   if_ready,  0);
      next_cyc; reset = 0;
      mid; check_eq("pr_c0_req", mem_req, 0); check_eq("pr_c0_drdy", d_ready, 0);
      next_cyc;
      mid; check_eq("pr_c1_req", mem_req, 1); check_eq("pr_c1_addr", mem_addr, 16'h0070);
      check_eq("pr_c1_drdy", d_ready, 0);
      next_cyc;
      mid; check_eq("pr_c2_drdy", d_ready, 1); check_eq("pr_c2_data", d_rdata, 16'h5A5A);
      next_cyc; d_rd = 0;
      mid;

      // Write (with d_rd also high) keeps the previous read data
      next_cyc; d_rd = 1; d_wr = 1; d_addr = 16'h0071; d_wdata = 16'h1111;
      mid;
      next_cyc;
      mid; check_eq("wp_c1_we", mem_we, 1); check_eq("wp_c1_wdata", mem_wdata, 16'h1111);
      next_cyc;
      mid; check_eq("wp_c2_drdy", d_ready, 1); check_eq("wp_c2_data", d_rdata, 16'h5A5A);
      next_cyc; d_rd = 0; d_wr = 0;
      mid; check_eq("wp_c3_stall", stall, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
